// File: rtl/arp_rx_gmii_pkg.sv
// Shared Ethernet/ARP constants and FSM state encodings
// used by the ARP receive and transmit paths.
package arp_rx_gmii_pkg;

   localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
   localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
   localparam logic [15:0] ARP_PTYPE_IP  = 16'h0800;
   localparam logic [15:0] ARP_OP_REQ    = 16'h0001;
   localparam logic [15:0] ARP_OP_REPLY  = 16'h0002;

   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE      = 8'hD5;
   localparam logic [7:0] BCAST_BYTE    = 8'hFF;
   localparam logic [7:0] ARP_HLEN      = 8'h06;
   localparam logic [7:0] ARP_PLEN      = 8'h04;

   localparam logic [4:0] PREAMBLE_LEN = 5'd7;
   localparam logic [4:0] ETH_HEAD_LEN = 5'd14;
   localparam logic [4:0] ARP_DATA_LEN = 5'd28;
   localparam logic [4:0] ARP_TIP_OFS  = 5'd24;

   // Fixed leading six bytes of an Ethernet/IPv4 ARP body
   localparam logic [47:0] ARP_HDR_FIX =
      {ARP_HTYPE_ETH, ARP_PTYPE_IP, ARP_HLEN, ARP_PLEN};

   localparam int ST_IDLE_B     = 0;
   localparam int ST_PREAMBLE_B = 1;
   localparam int ST_ETH_HEAD_B = 2;
   localparam int ST_ARP_DATA_B = 3;
   localparam int ST_RX_END_B   = 4;

   typedef enum logic [4:0] {
      st_idle     = 5'b00001,
      st_preamble = 5'b00010,
      st_eth_head = 5'b00100,
      st_arp_data = 5'b01000,
      st_rx_end   = 5'b10000
   } state_t;

   // Byte idx of a 48-bit field, idx 0 = first byte on the wire
   function automatic logic [7:0] byte_of48(
      input logic [47:0] v,
      input logic [2:0]  idx
   );
      logic [47:0] s;
      s = v << {idx, 3'b000};
      return s[47:40];
   endfunction

   // Byte idx of a 32-bit field, idx 0 = first byte on the wire
   function automatic logic [7:0] byte_of32(
      input logic [31:0] v,
      input logic [1:0]  idx
   );
      logic [31:0] s;
      s = v << {idx, 3'b000};
      return s[31:24];
   endfunction

endpackage

// File: rtl/arp_rx_gmii.sv
// ARP receive parser on the GMII RX byte stream: filters frames
// for this board and reports sender MAC/IP and opcode.
module arp_rx_gmii
   import arp_rx_gmii_pkg::*;
#(
   parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
   parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        gmii_rx_dv,
   input  logic [7:0]  gmii_rxd,
   output logic        arp_rx_done,
   output logic        arp_rx_type,
   output logic [47:0] src_mac,
   output logic [31:0] src_ip
);

   state_t      state;
   state_t      state_nx;
   logic [4:0]  cnt;
   logic [4:0]  cnt_nx;

   logic        mac_err;
   logic        bc_err;
   logic        arp_err;
   logic [7:0]  type_hi;
   logic        op_reply;
   logic [47:0] sh_mac;
   logic [31:0] sh_ip;

   logic        first;
   logic        mac_miss;
   logic        bc_miss;
   logic        arp_miss;
   logic        mac_err_nx;
   logic        bc_err_nx;
   logic        arp_err_nx;
   logic        eth_ok;
   logic        arp_pass;

   // State register and byte counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= st_idle;
         cnt   <= 5'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Next-state and counter logic; dv loss mid-frame aborts to idle
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (1'b1)
         state[ST_IDLE_B]: begin
            cnt_nx = 5'd0;
            if (gmii_rx_dv) begin
               if (gmii_rxd == PREAMBLE_BYTE) begin
                  state_nx = st_preamble;
                  cnt_nx   = 5'd1;
               end else begin
                  state_nx = st_rx_end;
               end
            end
         end
         state[ST_PREAMBLE_B]: begin
            if (!gmii_rx_dv) begin
               state_nx = st_idle;
               cnt_nx   = 5'd0;
            end else if (cnt < PREAMBLE_LEN) begin
               if (gmii_rxd == PREAMBLE_BYTE) begin
                  cnt_nx = cnt + 5'd1;
               end else begin
                  state_nx = st_rx_end;
                  cnt_nx   = 5'd0;
               end
            end else begin
               cnt_nx = 5'd0;
               if (gmii_rxd == SFD_BYTE) begin
                  state_nx = st_eth_head;
               end else begin
                  state_nx = st_rx_end;
               end
            end
         end
         state[ST_ETH_HEAD_B]: begin
            if (!gmii_rx_dv) begin
               state_nx = st_idle;
               cnt_nx   = 5'd0;
            end else if (cnt == ETH_HEAD_LEN - 5'd1) begin
               cnt_nx = 5'd0;
               if (eth_ok) begin
                  state_nx = st_arp_data;
               end else begin
                  state_nx = st_rx_end;
               end
            end else begin
               cnt_nx = cnt + 5'd1;
            end
         end
         state[ST_ARP_DATA_B]: begin
            if (!gmii_rx_dv) begin
               state_nx = st_idle;
               cnt_nx   = 5'd0;
            end else if (cnt == ARP_DATA_LEN - 5'd1) begin
               state_nx = st_rx_end;
               cnt_nx   = 5'd0;
            end else begin
               cnt_nx = cnt + 5'd1;
            end
         end
         state[ST_RX_END_B]: begin
            cnt_nx = 5'd0;
            if (!gmii_rx_dv) begin
               state_nx = st_idle;
            end
         end
         default: begin
            state_nx = st_idle;
            cnt_nx   = 5'd0;
         end
      endcase
   end

   // Per-byte header checks and the frame accept decisions
   always_comb begin
      first    = (cnt == 5'd0);
      mac_miss = 1'b0;
      bc_miss  = 1'b0;
      arp_miss = 1'b0;
      if (cnt < 5'd6) begin
         mac_miss = gmii_rxd != byte_of48(BOARD_MAC, cnt[2:0]);
         bc_miss  = gmii_rxd != BCAST_BYTE;
      end
      if (cnt < 5'd6) begin
         arp_miss = gmii_rxd != byte_of48(ARP_HDR_FIX, cnt[2:0]);
      end else if (cnt == 5'd6) begin
         arp_miss = gmii_rxd != ARP_OP_REQ[15:8];
      end else if (cnt == 5'd7) begin
         arp_miss = (gmii_rxd != ARP_OP_REQ[7:0])
                  && (gmii_rxd != ARP_OP_REPLY[7:0]);
      end else if (cnt >= ARP_TIP_OFS) begin
         arp_miss = gmii_rxd != byte_of32(BOARD_IP, cnt[1:0]);
      end
      mac_err_nx = (mac_err & ~first) | mac_miss;
      bc_err_nx  = (bc_err & ~first) | bc_miss;
      arp_err_nx = (arp_err & ~first) | arp_miss;
      eth_ok     = ~(mac_err_nx & bc_err_nx)
                 & ({type_hi, gmii_rxd} == ETH_TYPE_ARP);
      arp_pass   = state[ST_ARP_DATA_B] & gmii_rx_dv
                 & (cnt == ARP_DATA_LEN - 5'd1) & ~arp_err_nx;
   end

   // Mismatch flags, EtherType high byte and sender shadow registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mac_err  <= 1'b0;
         bc_err   <= 1'b0;
         arp_err  <= 1'b0;
         type_hi  <= 8'd0;
         op_reply <= 1'b0;
         sh_mac   <= 48'd0;
         sh_ip    <= 32'd0;
      end else if (gmii_rx_dv) begin
         if (state[ST_ETH_HEAD_B]) begin
            mac_err <= mac_err_nx;
            bc_err  <= bc_err_nx;
            if (cnt == 5'd12) begin
               type_hi <= gmii_rxd;
            end
         end
         if (state[ST_ARP_DATA_B]) begin
            arp_err <= arp_err_nx;
            if (cnt == 5'd7) begin
               op_reply <= gmii_rxd == ARP_OP_REPLY[7:0];
            end
            if (cnt >= 5'd8 && cnt <= 5'd13) begin
               sh_mac <= {sh_mac[39:0], gmii_rxd};
            end
            if (cnt >= 5'd14 && cnt <= 5'd17) begin
               sh_ip <= {sh_ip[23:0], gmii_rxd};
            end
         end
      end
   end

   // Done pulse; published fields change only with done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arp_rx_done <= 1'b0;
         arp_rx_type <= 1'b0;
         src_mac     <= 48'd0;
         src_ip      <= 32'd0;
      end else begin
         arp_rx_done <= arp_pass;
         if (arp_pass) begin
            arp_rx_type <= op_reply;
            src_mac     <= sh_mac;
            src_ip      <= sh_ip;
         end
      end
   end

endmodule
